uart_tx_byte: RTL and testbench

UART_TX_BYTE -- requirements
Module: uart_tx_byte

---
 rtl/crypt_pkg.sv | 8 +
 rtl/baud_counter.sv | 16 +
 rtl/uart_tx_byte.sv | 64 ++++++
 tb/tb_uart_tx_byte.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/crypt_pkg.sv
// crypt_pkg: framing constants shared by the crypt UART transmitter and receiver
package crypt_pkg;
  localparam int CLKS_PER_BIT_DEFAULT = 104;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] STOP = 2'd3;
endpackage

// File: rtl/baud_counter.sv
// baud_counter: bit-time counter whose tick marks the last cycle of each serial bit
module baud_counter import crypt_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    if (rst || clear || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serial transmitter taking one byte per valid/ready handshake
module uart_tx_byte import crypt_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  logic [1:0] state;
  logic [7:0] sh;
  logic [2:0] idx;
  logic tick;
  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .clear(state == IDLE),
    .tick(tick)
  );
  assign ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      done <= 1'b0;
      sh <= '0;
      idx <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (valid) begin
          state <= START;
          sh <= data_in;
          tx <= 1'b0;
          idx <= '0;
        end
      end else if (tick)
        case (state)
          START: begin
            state <= DATA;
            tx <= sh[0];
            sh <= sh >> 1;
          end
          DATA:
            if (idx == 3'd7) begin
              state <= STOP;
              tx <= 1'b1;
            end else begin
              tx <= sh[0];
              sh <= sh >> 1;
              idx <= idx + 3'd1;
            end
          default: begin
            state <= IDLE;
            done <= 1'b1;
          end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_byte.sv
// tb_uart_tx_byte: randomized scoreboard bench decoding the serial line of uart_tx_byte
module tb_uart_tx_byte;
  localparam int C = 4;
  typedef struct { logic [7:0] b; int e0; } exp_t;
  logic clk = 0, rst = 1, valid = 0, valid2 = 0;
  logic [7:0] data_in = '0, data2 = '0;
  logic ready, tx, busy, done, ready2, tx2, busy2, done2;
  int cyc = 0, total = 0, pass = 0, done_seen = 0, exp_done = 0;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_tx_byte #(.CLKS_PER_BIT(C)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy), .done(done)
  );
  uart_tx_byte u_def (
    .clk(clk), .rst(rst), .data_in(data2), .valid(valid2),
    .ready(ready2), .tx(tx2), .busy(busy2), .done(done2)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  // Offer a byte; returns just after the acceptance edge with its cycle number.
  task automatic send(input logic [7:0] b, input bit keep, output int e0);
    int t = 0;
    exp_t it;
    @(negedge clk);
    data_in = b;
    valid = 1;
    while (ready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    chk("accept_wait", t < 2000, 1);
    @(posedge clk);
    #1;
    e0 = cyc;
    it.b = b;
    it.e0 = cyc;
    exp_q.push_back(it);
    exp_done++;
    if (!keep) valid = 0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && t < 5000) begin @(negedge clk); t++; end
    chk("idle_wait", t < 5000, 1);
  endtask
  // Line monitor: rebuilds each frame from tx samples, one per cycle.
  bit act = 0, ok_hold, ok_hs;
  int n, st;
  logic [9:0] bits;
  exp_t got;
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    if (!act && rst === 1'b0 && tx === 1'b0) begin
      act = 1; n = 0; st = cyc; ok_hold = 1; ok_hs = 1; bits = '0;
    end
    if (act) begin
      if (n < 10 * C) begin
        if (busy !== 1'b1) act = 0;
        else begin
          if (n % C == 0) bits[n / C] = tx;
          else if (tx !== bits[n / C]) ok_hold = 0;
          if (ready !== 1'b0) ok_hs = 0;
          n++;
        end
      end else begin
        act = 0;
        chk("done_pulse", done, 1);
        chk("bit_hold", ok_hold, 1);
        chk("ready_low_in_frame", ok_hs, 1);
        chk("start_stop_bits", {bits[9], bits[0]}, 2'b10);
        if (exp_q.size() == 0) chk("unexpected_frame", exp_q.size(), 1);
        else begin
          got = exp_q.pop_front();
          chk("byte", bits[8:1], got.b);
          chk("start_cycle", st - got.e0 + 1, 1);
          chk("done_cycle", cyc - got.e0 + 1, 10 * C + 1);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end
  initial begin
    int e0, e1, t, n0, f;
    bit ok, keep;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 0;
    send(8'hA5, 0, e0);
    wait_idle();
    send(8'h3C, 1, e0);
    send(8'hC3, 0, e1);
    chk("b2b_period", e1 - e0, 10 * C + 1);
    wait_idle();
    send(8'h00, 0, e0);
    repeat (4) @(negedge clk);
    data_in = 8'hFF;
    wait_idle();
    send(8'h5A, 0, e0);
    repeat (10) @(negedge clk);
    valid = 1;
    data_in = 8'hEE;
    repeat (3) @(negedge clk);
    valid = 0;
    wait_idle();
    send(8'h55, 0, e0);
    repeat (17) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    void'(exp_q.pop_back());
    exp_done--;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 1);
    send(8'h0F, 0, e0);
    wait_idle();
    @(negedge clk);
    rst = 1;
    valid = 1;
    data_in = 8'h77;
    @(negedge clk);
    rst = 0;
    valid = 0;
    ok = 1;
    repeat (50) begin
      @(negedge clk);
      ok &= (tx === 1'b1 && busy === 1'b0);
    end
    chk("rst_valid_idle", ok, 1);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      keep = 1'($urandom_range(0, 1));
      send(8'($urandom), keep, e0);
      if (!keep) data_in = 8'($urandom);
    end
    valid = 0;
    wait_idle();
    @(negedge clk);
    data2 = 8'h01;
    valid2 = 1;
    t = 0;
    while (ready2 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    @(posedge clk);
    #1;
    valid2 = 0;
    n0 = 0;
    t = 0;
    @(negedge clk);
    while (tx2 === 1'b0 && t < 2000) begin n0++; t++; @(negedge clk); end
    chk("def_start_bit", n0, 104);
    f = n0;
    while (done2 !== 1'b1 && t < 3000) begin f++; t++; @(negedge clk); end
    chk("def_frame", f, 1040);
    chk("def_idle_busy", busy2, 0);
    repeat (2) @(negedge clk);
    chk("done_count", done_seen, exp_done);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
